// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem request, one held word for decode,
// redirect from execute and a sticky halt that only reset clears.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            flush, flush_nxt;
  logic [31:0]     inst_reg, inst_reg_nxt;
  logic [XLEN-1:0] redir_target;

  assign redir_target = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REQ;
      pc       <= XLEN'(RESET_PC);
      flush    <= 1'b0;
      inst_reg <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      flush    <= flush_nxt;
      inst_reg <= inst_reg_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    flush_nxt    = flush;
    inst_reg_nxt = inst_reg;
    case (state)
      ST_REQ: begin
        if (redirect_valid) pc_nxt = redir_target;
        if (imem_req_ready) begin
          state_nxt = ST_WAIT;
          // A request issued in the redirect cycle carries the stale pc.
          flush_nxt = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) pc_nxt = redir_target;
        if (imem_rsp_valid) begin
          flush_nxt = 1'b0;
          if (flush || redirect_valid) begin
            state_nxt = ST_REQ;
          end else begin
            inst_reg_nxt = imem_rsp_data;
            state_nxt    = ST_HOLD;
          end
        end else if (redirect_valid) begin
          flush_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        // Priority: halt on handshake, then redirect, then sequential pc.
        if (inst_ready && halt) begin
          state_nxt = ST_HALT;
        end else if (inst_ready) begin
          state_nxt = ST_REQ;
          pc_nxt    = redirect_valid ? redir_target : pc + XLEN'(4);
        end else if (redirect_valid) begin
          state_nxt = ST_REQ;
          pc_nxt    = redir_target;
        end
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  assign imem_req_valid = !rst && (state == ST_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = !rst && (state == ST_HOLD);
  assign inst           = inst_reg;
  assign inst_pc        = pc;
  assign halted         = (state == ST_HALT);

endmodule
